pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath payload width in bits (operands, PC+4, instruction).
REQ-002 SHALL have parameter CTRL_W, default 16, meaning control-bundle width in bits (RegWrite, MemRead, ALUOp, ...).
REQ-003 SHALL have parameter SKID_EN, default 1, meaning 1 = two-entry skid buffer, 0 = single entry with combinational In_Ready.
REQ-004 Clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 Flush  in  1  synchronous kill of all held entries.
REQ-007 In_Valid  in  1  upstream stage presents an entry.
REQ-008 In_Ready  out  1  this stage accepts an entry this cycle.
REQ-009 In_Ctrl  in  CTRL_W  upstream control bundle.
REQ-010 In_Data  in  DATA_W  upstream payload.
REQ-011 Out_Valid  out  1  head entry valid toward downstream.
REQ-012 Out_Ready  in  1  downstream consumes the head entry this cycle.
REQ-013 Out_Ctrl  out  CTRL_W  head control bundle; all-zero whenever Out_Valid=0.
REQ-014 Out_Data  out  DATA_W  head payload.
REQ-015 Occupancy  out  2  number of held entries (0..2).

Function
REQ-016 Accept = In_Valid & In_Ready; Pop = Out_Valid & Out_Ready; only these two events change contents.
REQ-017 State machine SHALL have states EMPTY, ONE (head valid), FULL (head + skid valid); FULL is unreachable when SKID_EN=0.
REQ-018 EMPTY: Accept -> ONE, head <= input; entry visible on Out_* one cycle after Accept (latency 1).
REQ-019 ONE: Accept & Pop -> ONE, head <= input; Accept & !Pop -> FULL, skid <= input; !Accept & Pop -> EMPTY; otherwise hold.
REQ-020 FULL: Pop -> ONE, head <= skid; !Pop -> hold; no Accept possible.
REQ-021 SKID_EN=1: In_Ready SHALL be a register output, 1 exactly when state != FULL.
REQ-022 SKID_EN=0: In_Ready = (state==EMPTY) | Out_Ready.
REQ-023 Order SHALL be preserved: entries leave in Accept order, none duplicated or dropped.
REQ-024 While Out_Valid=1 and Out_Ready=0, Out_Ctrl and Out_Data SHALL remain stable.
REQ-025 When Out_Valid=0, Out_Ctrl SHALL be zero (bubble carries no side effects); Out_Data holds its last value.
REQ-026 Flush=1 at a rising edge SHALL force EMPTY, clear head and skid (ctrl and data to zero), and discard any simultaneous Accept; Pop in the same cycle still counts as consumed downstream.
REQ-027 In_Ready SHALL be 1 in the cycle after Flush (SKID_EN=1).
REQ-028 Occupancy SHALL equal 0/1/2 for EMPTY/ONE/FULL, registered.

Reset
REQ-029 Reset low SHALL immediately force EMPTY, Out_Valid=0, Out_Ctrl=0, Out_Data=0, Occupancy=0, skid cleared, In_Ready=0 while asserted.
REQ-030 In_Ready SHALL rise on the first rising Clock edge after Reset deasserts; Reset asserted mid-transfer drops all held entries without emitting them.

Structure
REQ-031 Package pipe_stage_pkg SHALL hold the state typedef (EMPTY, ONE, FULL) and default width constants DATA_W_DEF=32, CTRL_W_DEF=16.
REQ-032 No sub-module; head and skid storage inline, ctrl and data stored as one concatenated CTRL_W+DATA_W vector.

Verification
REQ-033 Streaming: In_Valid=1, Out_Ready=1 for 8 cycles, data 0x10..0x17 -> Out_Data 0x10..0x17 in order, 1-cycle latency, In_Ready constantly 1, Occupancy=1.
REQ-034 Backpressure: Out_Ready=0 while sending 0xA1, 0xA2, 0xA3 -> Occupancy reaches 2, In_Ready=0 after 0xA2, 0xA3 held upstream; Out_Ready=1 -> outputs 0xA1, 0xA2, 0xA3 in order, none lost.
REQ-035 Flush in FULL with simultaneous In_Valid (data 0xFF) -> next cycle Out_Valid=0, Out_Ctrl=0, Out_Data=0, Occupancy=0, 0xFF never appears.
REQ-036 Asynchronous Reset low mid-cycle while holding ctrl 0xBEEF -> outputs zero before next Clock edge; after release first Accept of 0x55 emerges after 1 cycle.
REQ-037 SKID_EN=0 build: Out_Ready toggling 1,0,1,0 with continuous In_Valid -> In_Ready follows Out_Ready when ONE, Occupancy never exceeds 1, order preserved.
REQ-038 Random valid/ready (10k cycles, both parameter sets) against a FIFO scoreboard -> zero mismatches, Out_Ctrl zero whenever Out_Valid=0.

Source files
------------

// File: rtl/pipe_stage_pkg.sv
// pipe_stage_pkg: shared state encoding and default widths for pipe_stage_reg
//
// Contents:
//   DATA_W_DEF    default payload width (operands, PC+4, instruction)
//   CTRL_W_DEF    default control-bundle width
//   stage_state_t EMPTY / ONE (head valid) / FULL (head + skid valid)
//   occ_of()      maps a state to its entry count
package pipe_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    function automatic logic [1:0] occ_of(input stage_state_t s);
        return (s == FULL) ? 2'd2 : (s == ONE) ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with optional two-entry skid buffer
//
// Ports:
//   Clock      sole clock, rising edge
//   Reset      asynchronous, active-low; drops all entries, In_Ready low while asserted
//   Flush      synchronous kill of head and skid, discards a simultaneous accept
//   In_Valid   upstream presents an entry
//   In_Ready   this stage accepts an entry this cycle
//   In_Ctrl    upstream control bundle
//   In_Data    upstream payload
//   Out_Valid  head entry valid toward downstream
//   Out_Ready  downstream consumes the head entry this cycle
//   Out_Ctrl   head control bundle, forced to zero on a bubble
//   Out_Data   head payload, keeps its last value on a bubble
//   Occupancy  number of held entries (0..2), registered
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CTRL_W  = CTRL_W_DEF,
    parameter int SKID_EN = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [DATA_W-1:0] Out_Data,
    output logic [1:0]        Occupancy
);

    localparam int ENT_W = CTRL_W + DATA_W;

    stage_state_t     state_q, state_d;
    logic [ENT_W-1:0] head_q, head_d, skid_q, skid_d;
    logic [1:0]       occ_q;
    logic             rdy_q;
    logic             accept, pop;

    // Without the skid slot, ready must look through to Out_Ready so a full
    // head can be replaced in the same cycle it drains; Reset gates it low.
    assign In_Ready  = (SKID_EN != 0) ? rdy_q : (Reset & ((state_q == EMPTY) | Out_Ready));
    assign accept    = In_Valid & In_Ready;
    assign Out_Valid = (state_q != EMPTY);
    assign pop       = Out_Valid & Out_Ready;
    assign Out_Ctrl  = Out_Valid ? head_q[ENT_W-1:DATA_W] : '0;
    assign Out_Data  = head_q[DATA_W-1:0];
    assign Occupancy = occ_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    head_d  = {In_Ctrl, In_Data};
                end
            end
            ONE: begin
                if (accept && pop) begin
                    head_d = {In_Ctrl, In_Data};
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = {In_Ctrl, In_Data};
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = ONE;
                    head_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over everything; a pop in the same cycle is already
        // consumed downstream, so nothing further is needed for it.
        if (Flush) begin
            state_d = EMPTY;
            head_d  = '0;
            skid_d  = '0;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            occ_q   <= 2'd0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            occ_q   <= occ_of(state_d);
            rdy_q   <= (state_d != FULL);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg, skid (k=0) and no-skid (k=1) builds
module tb_pipe_stage_reg;

    typedef logic [47:0] ent_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        flush[2];
    logic        iv[2];
    logic        ir[2];
    logic [15:0] ic[2];
    logic [31:0] id[2];
    logic        ov[2];
    logic        ordy[2];
    logic [15:0] oc[2];
    logic [31:0] od[2];
    logic [1:0]  occ[2];

    ent_t q0[$];
    ent_t q1[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_stall[2];
    ent_t prev_out[2];

    always #5 Clock = ~Clock;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID_EN(1)) u_skid (
        .Clock(Clock), .Reset(Reset), .Flush(flush[0]),
        .In_Valid(iv[0]), .In_Ready(ir[0]), .In_Ctrl(ic[0]), .In_Data(id[0]),
        .Out_Valid(ov[0]), .Out_Ready(ordy[0]), .Out_Ctrl(oc[0]), .Out_Data(od[0]),
        .Occupancy(occ[0])
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID_EN(0)) u_noskid (
        .Clock(Clock), .Reset(Reset), .Flush(flush[1]),
        .In_Valid(iv[1]), .In_Ready(ir[1]), .In_Ctrl(ic[1]), .In_Data(id[1]),
        .Out_Valid(ov[1]), .Out_Ready(ordy[1]), .Out_Ctrl(oc[1]), .Out_Data(od[1]),
        .Occupancy(occ[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input ent_t e);
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every downstream handshake, checks
    // bubbles carry zero ctrl and stalled heads do not move.
    always @(negedge Clock) begin
        for (int k = 0; k < 2; k++) begin
            ent_t cur, e;
            cur = {oc[k], od[k]};
            if (!ov[k]) chk($sformatf("bubble_ctrl%0d", k), oc[k], 16'h0);
            if (Reset && prev_stall[k]) begin
                chk($sformatf("stall_valid%0d", k), ov[k], 1'b1);
                chk($sformatf("stall_stable%0d", k), cur, prev_out[k]);
            end
            if (ov[k] && ordy[k]) begin
                if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                    chk($sformatf("unexpected_out%0d", k), cur, 48'h0);
                    if (cur == 48'h0) begin
                        n_fail++;
                        $display("FAIL unexpected_out%0d: got %0h expected none", k, cur);
                    end
                end else begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("order%0d", k), cur, e);
                end
            end
            prev_stall[k] = Reset && ov[k] && !ordy[k] && !flush[k];
            prev_out[k]   = cur;
        end
    end

    task automatic send(input int k, input logic [15:0] c, input logic [31:0] d);
        int   t = 0;
        logic ok = 1'b0;
        iv[k] = 1'b1;
        ic[k] = c;
        id[k] = d;
        while (!ok && t < 20) begin
            @(negedge Clock);
            ok = ir[k];
            @(posedge Clock);
            t++;
        end
        if (ok) push(k, {c, d});
        else chk("send_timeout", 0, 1);
        #1 iv[k] = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    initial begin
        int   mocc, idx;
        logic acc_m, pop_m;
        logic acc[2];
        for (int k = 0; k < 2; k++) begin
            flush[k] = 0; iv[k] = 0; ic[k] = '0; id[k] = '0; ordy[k] = 0;
            prev_stall[k] = 0; prev_out[k] = '0;
        end
        // reset state
        cyc(2);
        for (int k = 0; k < 2; k++) begin
            chk("rst_in_ready", ir[k], 1'b0);
            chk("rst_out_valid", ov[k], 1'b0);
            chk("rst_out_ctrl", oc[k], 16'h0);
            chk("rst_out_data", od[k], 32'h0);
            chk("rst_occ", occ[k], 2'd0);
        end
        @(negedge Clock);
        #2 Reset = 1'b1;
        #1 chk("rdy_before_edge", ir[0], 1'b0);
        @(posedge Clock);
        #1 chk("rdy_after_edge", ir[0], 1'b1);

        // streaming
        ordy[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(0, 16'h0100 + 16'(i), 32'h10 + 32'(i));
            chk("stream_data", od[0], 32'h10 + 32'(i));
            chk("stream_valid", ov[0], 1'b1);
            chk("stream_occ", occ[0], 2'd1);
            chk("stream_rdy", ir[0], 1'b1);
        end
        cyc(3);
        chk("stream_drain_occ", occ[0], 2'd0);

        // backpressure
        ordy[0] = 1'b0;
        send(0, 16'h00A1, 32'hA1);
        chk("bp_occ1", occ[0], 2'd1);
        send(0, 16'h00A2, 32'hA2);
        chk("bp_occ2", occ[0], 2'd2);
        chk("bp_rdy_low", ir[0], 1'b0);
        iv[0] = 1'b1; ic[0] = 16'h00A3; id[0] = 32'hA3;
        repeat (2) begin
            cyc(1);
            chk("bp_hold_rdy", ir[0], 1'b0);
            chk("bp_hold_head", od[0], 32'hA1);
            chk("bp_hold_occ", occ[0], 2'd2);
        end
        ordy[0] = 1'b1;
        send(0, 16'h00A3, 32'hA3);
        cyc(4);
        chk("bp_drain_occ", occ[0], 2'd0);
        chk("bp_sb_empty", q0.size(), 0);

        // flush while FULL with a simultaneous offer
        ordy[0] = 1'b0;
        send(0, 16'h00B1, 32'hB1);
        send(0, 16'h00B2, 32'hB2);
        chk("fl_pre_occ", occ[0], 2'd2);
        flush[0] = 1'b1; iv[0] = 1'b1; ic[0] = 16'hFFFF; id[0] = 32'hFF;
        @(posedge Clock);
        q0.delete();
        #1 flush[0] = 1'b0; iv[0] = 1'b0;
        chk("fl_valid", ov[0], 1'b0);
        chk("fl_ctrl", oc[0], 16'h0);
        chk("fl_data", od[0], 32'h0);
        chk("fl_occ", occ[0], 2'd0);
        chk("fl_rdy", ir[0], 1'b1);
        ordy[0] = 1'b1;
        cyc(3);
        chk("fl_no_ghost", ov[0], 1'b0);

        // asynchronous reset mid-cycle
        ordy[0] = 1'b0;
        send(0, 16'hBEEF, 32'h1234);
        chk("ar_pre_ctrl", oc[0], 16'hBEEF);
        #3 Reset = 1'b0;
        #1;
        chk("ar_valid", ov[0], 1'b0);
        chk("ar_ctrl", oc[0], 16'h0);
        chk("ar_data", od[0], 32'h0);
        chk("ar_occ", occ[0], 2'd0);
        chk("ar_rdy", ir[0], 1'b0);
        q0.delete();
        q1.delete();
        @(negedge Clock);
        #2 Reset = 1'b1;
        cyc(1);
        ordy[0] = 1'b1;
        send(0, 16'h0055, 32'h55);
        chk("ar_first_data", od[0], 32'h55);
        chk("ar_first_valid", ov[0], 1'b1);
        cyc(3);

        // no-skid build with toggling Out_Ready
        mocc = 0;
        idx  = 0;
        for (int c = 0; c < 8; c++) begin
            ordy[1] = (c % 2 == 0);
            iv[1]   = 1'b1;
            ic[1]   = 16'h0200 + 16'(idx);
            id[1]   = 32'h20 + 32'(idx);
            @(negedge Clock);
            acc_m = (mocc == 0) || ordy[1];
            pop_m = (mocc == 1) && ordy[1];
            chk("ns_rdy", ir[1], acc_m);
            chk("ns_occ", occ[1], 2'(mocc));
            @(posedge Clock);
            if (acc_m) begin
                push(1, {ic[1], id[1]});
                idx++;
            end
            mocc = acc_m ? 1 : (pop_m ? 0 : mocc);
            #1;
        end
        iv[1] = 1'b0; ordy[1] = 1'b1;
        cyc(3);
        chk("ns_drain_occ", occ[1], 2'd0);
        chk("ns_sb_empty", q1.size(), 0);

        // random valid/ready on both builds
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0;
        end
        for (int n = 0; n < 10000; n++) begin
            @(negedge Clock);
            for (int k = 0; k < 2; k++) begin
                acc[k] = iv[k] && ir[k];
                if (occ[k] > 2'(1 + (k == 0 ? 1 : 0))) chk("rnd_occ_bound", occ[k], 2'd1);
            end
            @(posedge Clock);
            for (int k = 0; k < 2; k++) if (acc[k]) push(k, {ic[k], id[k]});
            #1;
            for (int k = 0; k < 2; k++) begin
                if (acc[k] || !iv[k]) begin
                    iv[k] = ($urandom_range(0, 3) != 0);
                    ic[k] = 16'($urandom);
                    id[k] = $urandom;
                end
                ordy[k] = ($urandom_range(0, 3) != 0);
            end
        end
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b1;
        end
        cyc(5);
        chk("rnd_sb_empty0", q0.size(), 0);
        chk("rnd_sb_empty1", q1.size(), 0);
        chk("rnd_occ0", occ[0], 2'd0);
        chk("rnd_occ1", occ[1], 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
